// File: rtl/locker_access_ctrl.sv
// Round-robin sequencer sharing one serial password locker between a front panel (0) and an admin console (1).
// Optional build macro ADMIN_BYPASS_EN lets the admin console be serviced during a lockout.
module locker_access_ctrl #(
    parameter int RESULT_LAT     = 1,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_mode,
    input  logic [31:0] req_code,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    output logic        resp_unlock,
    output logic        resp_err,
    output logic        resp_alert,
    output logic [3:0]  lk_code,
    output logic        lk_mode,
    output logic        lk_en,
    input  logic        lk_unlock,
    input  logic        lk_err,
    input  logic        lk_alert,
    output logic        busy,
    output logic        locked_out
);

    localparam int WAIT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT + 1) : 1;
    localparam int LO_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RESP,
        S_LOCKOUT
    } state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                gnt_q, gnt_d;
    logic [15:0]         code_q, code_d;
    logic                mode_q, mode_d;
    logic [1:0]          dig_idx_q, dig_idx_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [LO_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [3:0]          lk_code_q, lk_code_d;
    logic                lk_mode_q, lk_mode_d;
    logic                lk_en_q, lk_en_d;
    logic [1:0]          resp_valid_q, resp_valid_d;
    logic                resp_unlock_q, resp_unlock_d;
    logic                resp_err_q, resp_err_d;
    logic                resp_alert_q, resp_alert_d;

    logic                arb_idx;
    logic                start;
    logic [3:0]          next_digit;

    function automatic logic [3:0] digit_sel(input logic [15:0] code, input logic [1:0] idx);
        return code[{idx, 2'b00} +: 4];
    endfunction

    // Pointer names the favoured requester; a lone valid requester wins regardless.
    always_comb begin
        arb_idx = ptr_q;
        if (!req_valid[ptr_q]) begin
            arb_idx = ~ptr_q;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (!RST) begin
            if (state_q == S_IDLE && (|req_valid)) begin
                req_ready[arb_idx] = 1'b1;
            end
`ifdef ADMIN_BYPASS_EN
            if (state_q == S_LOCKOUT) begin
                req_ready[1] = req_valid[1];
            end
`endif
        end
    end

    assign start      = |req_ready;
    assign next_digit = digit_sel(code_q, 2'(dig_idx_q + 2'd1));

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        code_d        = code_q;
        mode_d        = mode_q;
        dig_idx_d     = dig_idx_q;
        wait_cnt_d    = wait_cnt_q;
        lock_cnt_d    = lock_cnt_q;
        lk_en_d       = 1'b0;
        lk_code_d     = 4'd0;
        lk_mode_d     = 1'b1;
        resp_valid_d  = 2'b00;
        resp_unlock_d = 1'b0;
        resp_err_d    = 1'b0;
        resp_alert_d  = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_SEND: begin
                if (dig_idx_q == 2'd3) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    dig_idx_d = 2'(dig_idx_q + 2'd1);
                    lk_en_d   = 1'b1;
                    lk_code_d = next_digit;
                    lk_mode_d = mode_q;
                end
            end
            // Verdict is captured RESULT_LAT cycles after the last strobe.
            S_WAIT: begin
                if (wait_cnt_q == WAIT_W'(RESULT_LAT)) begin
                    state_d              = S_RESP;
                    resp_valid_d[gnt_q]  = 1'b1;
                    resp_unlock_d        = lk_unlock;
                    resp_err_d           = lk_err;
                    resp_alert_d         = lk_alert;
                end else begin
                    wait_cnt_d = WAIT_W'(wait_cnt_q + WAIT_W'(1));
                end
            end
            S_RESP: begin
                if (resp_alert_q) begin
                    state_d    = S_LOCKOUT;
                    lock_cnt_d = LO_W'(LOCKOUT_CYCLES);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt_q <= LO_W'(1)) begin
                    state_d    = S_IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = LO_W'(lock_cnt_q - LO_W'(1));
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A grant (from IDLE, or the admin bypass in LOCKOUT) overrides the above.
        if (start) begin
            state_d    = S_SEND;
            gnt_d      = arb_idx;
            ptr_d      = ~arb_idx;
            code_d     = arb_idx ? req_code[31:16] : req_code[15:0];
            mode_d     = req_mode[arb_idx];
            dig_idx_d  = 2'd0;
            lock_cnt_d = '0;
            lk_en_d    = 1'b1;
            lk_code_d  = arb_idx ? req_code[19:16] : req_code[3:0];
            lk_mode_d  = req_mode[arb_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            ptr_q         <= 1'b0;
            gnt_q         <= 1'b0;
            code_q        <= 16'd0;
            mode_q        <= 1'b0;
            dig_idx_q     <= 2'd0;
            wait_cnt_q    <= '0;
            lock_cnt_q    <= '0;
            lk_code_q     <= 4'd0;
            lk_mode_q     <= 1'b1;
            lk_en_q       <= 1'b0;
            resp_valid_q  <= 2'b00;
            resp_unlock_q <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_alert_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            code_q        <= code_d;
            mode_q        <= mode_d;
            dig_idx_q     <= dig_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            lk_code_q     <= lk_code_d;
            lk_mode_q     <= lk_mode_d;
            lk_en_q       <= lk_en_d;
            resp_valid_q  <= resp_valid_d;
            resp_unlock_q <= resp_unlock_d;
            resp_err_q    <= resp_err_d;
            resp_alert_q  <= resp_alert_d;
        end
    end

    assign lk_code     = lk_code_q;
    assign lk_mode     = lk_mode_q;
    assign lk_en       = lk_en_q;
    assign resp_valid  = resp_valid_q;
    assign resp_unlock = resp_unlock_q;
    assign resp_err    = resp_err_q;
    assign resp_alert  = resp_alert_q;
    assign busy        = (state_q != S_IDLE);
    assign locked_out  = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_locker_access_ctrl.sv
// Bench for locker_access_ctrl: timeline-based reference model checked every cycle plus directed scenarios.
module tb_locker_access_ctrl;

    localparam int RL = 1;
    localparam int LO = 8;
`ifdef ADMIN_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_mode = 2'b00;
    logic [31:0] req_code = 32'd0;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic        resp_unlock, resp_err, resp_alert;
    logic [3:0]  lk_code;
    logic        lk_mode, lk_en;
    logic        lk_unlock = 1'b0, lk_err = 1'b0, lk_alert = 1'b0;
    logic        busy, locked_out;

    always #5 CLK = ~CLK;

    locker_access_ctrl #(.RESULT_LAT(RL), .LOCKOUT_CYCLES(LO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_mode(req_mode), .req_code(req_code),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_unlock(resp_unlock), .resp_err(resp_err), .resp_alert(resp_alert),
        .lk_code(lk_code), .lk_mode(lk_mode), .lk_en(lk_en),
        .lk_unlock(lk_unlock), .lk_err(lk_err), .lk_alert(lk_alert),
        .busy(busy), .locked_out(locked_out)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction is a timeline measured from its grant cycle.
    bit          m_init = 0, m_act = 0, m_gnt = 0, m_ptr = 0, m_mode = 0;
    bit          m_unl = 0, m_err = 0, m_alr = 0;
    int          m_t0 = 0, m_lock = 0;
    logic [15:0] m_code = 16'd0;

    logic [1:0]  acc = 2'b00;
    int g_idx[$], g_cyc[$], c_log[$], md_log[$], r_vec[$], r_cyc[$], r_unl[$], r_alr[$];
    int lo_cnt = 0, lo_first = -1;

    always @(negedge CLK) begin : mon
        int d;
        bit e_en, e_busy, e_lo, pick;
        logic [3:0] e_code;
        logic e_mode;
        logic [1:0] e_rv, e_ready;
        d      = cyc - m_t0;
        e_en   = m_act && d >= 1 && d <= 4;
        e_code = e_en ? 4'((m_code >> (4 * (d - 1))) & 16'hF) : 4'd0;
        e_mode = e_en ? m_mode : 1'b1;
        e_rv   = (m_act && d == 5 + RL) ? (m_gnt ? 2'b10 : 2'b01) : 2'b00;
        e_busy = (m_act && d >= 1) || (m_lock > 0);
        e_lo   = (m_lock > 0);
        pick   = req_valid[m_ptr] ? m_ptr : !m_ptr;
        e_ready = 2'b00;
        if (!RST) begin
            if (!m_act && m_lock == 0 && req_valid != 2'b00) e_ready[pick] = 1'b1;
            else if (BYPASS && !m_act && m_lock > 0 && req_valid[1]) e_ready[1] = 1'b1;
        end
        if (m_init) begin
            chk("req_ready", req_ready, e_ready);
            chk("lk_en", lk_en, e_en);
            chk("lk_code", lk_code, e_code);
            chk("lk_mode", lk_mode, e_mode);
            chk("resp_valid", resp_valid, e_rv);
            chk("resp_unlock", resp_unlock, (e_rv != 0) ? m_unl : 1'b0);
            chk("resp_err", resp_err, (e_rv != 0) ? m_err : 1'b0);
            chk("resp_alert", resp_alert, (e_rv != 0) ? m_alr : 1'b0);
            chk("busy", busy, e_busy);
            chk("locked_out", locked_out, e_lo);
            if (req_ready & req_valid) begin g_idx.push_back(req_ready[1]); g_cyc.push_back(cyc); end
            if (lk_en) begin c_log.push_back(lk_code); md_log.push_back(lk_mode); end
            if (resp_valid != 0) begin
                r_vec.push_back(resp_valid); r_cyc.push_back(cyc);
                r_unl.push_back(resp_unlock); r_alr.push_back(resp_alert);
            end
            if (locked_out) begin
                if (lo_cnt == 0) lo_first = cyc;
                lo_cnt++;
            end
        end
        acc = req_valid & req_ready;
        if (RST) begin
            m_init = 1; m_act = 0; m_ptr = 0; m_lock = 0;
        end else if (m_act) begin
            if (d == 4 + RL) begin m_unl = lk_unlock; m_err = lk_err; m_alr = lk_alert; end
            if (d == 5 + RL) begin
                m_act = 0;
                if (m_alr) m_lock = LO;
            end
        end else if (e_ready != 2'b00) begin
            m_act  = 1; m_t0 = cyc; m_gnt = e_ready[1];
            m_code = m_gnt ? req_code[31:16] : req_code[15:0];
            m_mode = req_mode[m_gnt];
            m_ptr  = !m_gnt; m_lock = 0;
        end else if (m_lock > 0) begin
            m_lock--;
        end
        cyc++;
    end

    // Stimulus: requesters hold their request until accepted unless in auto mode.
    logic [1:0] pend = 2'b00, auto = 2'b00;

    task automatic step();
        @(posedge CLK);
        #1;
        pend = pend & ~(acc & ~auto);
        req_valid = pend;
    endtask

    task automatic request(input int i, input logic [15:0] code, input logic mode);
        if (i == 0) req_code[15:0] = code; else req_code[31:16] = code;
        req_mode[i] = mode;
        pend[i] = 1'b1;
        req_valid = pend;
        #1;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((pend != 0 || busy || locked_out) && n < max) begin step(); n++; end
        if (n >= max) begin
            checks++; failures++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", max);
        end
    endtask

    task automatic clr_logs();
        g_idx.delete(); g_cyc.delete(); c_log.delete(); md_log.delete();
        r_vec.delete(); r_cyc.delete(); r_unl.delete(); r_alr.delete();
        lo_cnt = 0; lo_first = -1;
    endtask

    function automatic logic [15:0] pack4(input int start);
        logic [15:0] v = 16'd0;
        for (int k = 0; k < 4; k++) if (start + k < c_log.size()) v[4*k +: 4] = 4'(c_log[start + k]);
        return v;
    endfunction

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        step(); step(); step();
        // Reset state, with both requesters asserting during reset.
        req_valid = 2'b11; #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lk_en", lk_en, 1'b0);
        chk("rst_lk_mode", lk_mode, 1'b1);
        chk("rst_lk_code", lk_code, 4'd0);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_locked_out", locked_out, 1'b0);
        step();

        // 1: validate 0,1,0,3 from requester 0, locker unlocks.
        clr_logs();
        RST = 1'b0; lk_unlock = 1'b1;
        request(0, 16'h3010, 1'b1);
        chk("t1_ready", req_ready, 2'b01);
        wait_idle(30);
        chk("t1_grant_idx", g_idx[0], 0);
        chk("t1_codes", pack4(0), 16'h3010);
        chk("t1_nstrobes", c_log.size(), 4);
        chk("t1_resp_latency", r_cyc[0] - g_cyc[0], 6);
        chk("t1_resp_vec", r_vec[0], 2'b01);
        chk("t1_resp_unlock", r_unl[0], 1);

        // 2: both continuously valid from reset -> 0,1,0,1.
        RST = 1'b1; step(); RST = 1'b0;
        clr_logs(); lk_unlock = 1'b0;
        auto = 2'b11;
        request(0, 16'h4321, 1'b1);
        request(1, 16'h8765, 1'b1);
        n = 0;
        while (g_idx.size() < 4 && n < 80) begin step(); n++; end
        auto = 2'b00; pend = 2'b00; req_valid = 2'b00;
        wait_idle(30);
        chk("t2_ngrants", g_idx.size(), 4);
        chk("t2_order", {g_idx[3][0], g_idx[2][0], g_idx[1][0], g_idx[0][0]}, 4'b1010);
        chk("t2_resp_order", {r_vec[3][1:0], r_vec[2][1:0], r_vec[1][1:0], r_vec[0][1:0]}, 8'h99);
        chk("t2_codes0", pack4(0), 16'h4321);
        chk("t2_codes1", pack4(4), 16'h8765);

        // 5: set-password from requester 1, digits 5,6,7,8.
        clr_logs();
        request(1, 16'h8765, 1'b0);
        wait_idle(30);
        chk("t5_grant_idx", g_idx[0], 1);
        chk("t5_codes", pack4(0), 16'h8765);
        chk("t5_modes", md_log[0] | md_log[1] | md_log[2] | md_log[3], 0);
        chk("t5_resp_vec", r_vec[0], 2'b10);

        // 3: alert -> 8-cycle lockout; requester 0 re-requests while busy.
        clr_logs(); lk_alert = 1'b1;
        request(0, 16'hFFAA, 1'b1);
        step();
        request(0, 16'h1111, 1'b1);
        n = 0;
        while (lo_cnt == 0 && n < 30) begin step(); n++; end
        lk_alert = 1'b0;
        wait_idle(60);
        chk("t3_hex_digits", pack4(0), 16'hFFAA);
        chk("t3_resp_alert", r_alr[0], 1);
        chk("t3_lockout_len", lo_cnt, LO);
        chk("t3_regrant_cycle", g_cyc[1] - lo_first, LO);
        chk("t3_nresp", r_vec.size(), 2);

        // 4: reset in the third SEND cycle, then requester 0 beats requester 1.
        clr_logs();
        request(0, 16'h1234, 1'b1);
        step(); step(); step();
        RST = 1'b1;
        req_code[31:16] = 16'h5555; req_mode[1] = 1'b1;
        pend = 2'b11; req_valid = 2'b11; #1;
        chk("t4_ready_in_rst", req_ready, 2'b00);
        step();
        RST = 1'b0; #1;
        chk("t4_lk_en_after", lk_en, 1'b0);
        chk("t4_busy_after", busy, 1'b0);
        chk("t4_no_resp", resp_valid, 2'b00);
        chk("t4_ready_after", req_ready, 2'b01);
        wait_idle(60);
        chk("t4_nstrobes", c_log.size(), 11);
        chk("t4_ngrants", g_idx.size(), 3);
        chk("t4_order", {g_idx[2][0], g_idx[1][0], g_idx[0][0]}, 3'b100);
        chk("t4_nresp", r_vec.size(), 2);
        chk("t4_resp0", r_vec[0], 2'b01);

        // 6: admin console request during lockout.
        clr_logs(); lk_alert = 1'b1;
        request(0, 16'h2222, 1'b1);
        n = 0;
        while (lo_cnt == 0 && n < 30) begin step(); n++; end
        lk_alert = 1'b0; lk_unlock = 1'b1;
        request(1, 16'h9999, 1'b1);
        wait_idle(60);
        chk("t6_admin_resp", r_vec[1], 2'b10);
        if (BYPASS) begin
            chk("t6_bypass_grant", g_cyc[1] - lo_first, 1);
            chk("t6_bypass_lockout", lo_cnt, 2);
        end else begin
            chk("t6_grant_after_lockout", g_cyc[1] - lo_first, LO);
            chk("t6_lockout_len", lo_cnt, LO);
        end

        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/locker_access_ctrl.md
Name: locker_access_ctrl

Overview:
Sequencer and arbiter that shares one serial password locker between two keypad requesters: requester 0 is the front panel, requester 1 is the admin console.
- Grants one requester at a time, round-robin.
- Streams the latched 4-digit code into the locker one digit per strobe, samples the locker's verdict and returns it to the granted requester.
- Enforces a timed lockout whenever the locker raises alert.

Parameters:
RESULT_LAT, 1, cycles from last digit strobe to valid lk_unlock/lk_err/lk_alert (>=1)
LOCKOUT_CYCLES, 1000, cycles requests are refused after an alert (>=1)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
req_valid  in  2  per-requester request; held until req_ready
req_mode  in  2  per-requester mode: 1=validate, 0=set password
req_code  in  32  two 16-bit codes: [16i+3:16i]=digit0 (entered first) ... [16i+15:16i+12]=digit3
req_ready  out  2  one-hot accept, combinational, only in IDLE
resp_valid  out  2  one-hot one-cycle response pulse
resp_unlock  out  1  sampled lk_unlock, qualified by resp_valid
resp_err  out  1  sampled lk_err, qualified by resp_valid
resp_alert  out  1  sampled lk_alert, qualified by resp_valid
lk_code  out  4  digit to locker
lk_mode  out  1  mode to locker
lk_en  out  1  digit strobe; locker consumes lk_code only when 1
lk_unlock  in  1  locker Unlock
lk_err  in  1  locker Err
lk_alert  in  1  locker alert
busy  out  1  state != IDLE
locked_out  out  1  state == LOCKOUT

Behaviour:
- Reset values (next edge with RST=1):
  - State, ports: state=IDLE; req_ready=0 while RST high; resp_*=0; lk_code=0, lk_mode=1, lk_en=0; busy=0; locked_out=0.
  - Internals: round-robin pointer favours requester 0; digit index and lockout counter cleared.
- States: IDLE -> SEND -> WAIT -> RESP -> (LOCKOUT ->) IDLE.
- IDLE arbitration:
  - Grant the requester with req_valid=1 per the round-robin pointer; req_ready of the winner is 1 in that cycle (T).
  - At the edge ending T: latch code and mode, move the pointer to the other requester, go to SEND.
  - If only one requester is valid it wins regardless of the pointer.
  - A request withdrawn before ready is simply not served.
- SEND, cycles T+1..T+4:
  - lk_en=1; lk_code=digit0..digit3 in order; lk_mode=latched mode.
  - All lk_* outputs are registered.
- WAIT: lk_en=0, lk_code=0, lk_mode=1. Locker outputs are sampled at the end of cycle T+4+RESULT_LAT.
- RESP, cycle T+5+RESULT_LAT:
  - resp_valid[granted]=1 with the sampled values; no backpressure.
  - Next state is LOCKOUT if the sampled alert=1, else IDLE.
  - Earliest next grant is T+6+RESULT_LAT.
- LOCKOUT:
  - Lasts exactly LOCKOUT_CYCLES cycles; locked_out=1, busy=1, req_ready=0, lk_en=0, then IDLE.
  - Counter width $clog2(LOCKOUT_CYCLES+1); counts down to 1, then exits.
- Requests arriving while busy are held off (req_ready=0) and not queued internally.
- Set-mode transactions follow the same sequence; the verdict is passed through unmodified.
- Digit values are not range-checked; 0xA-0xF pass through.
- RST during any state:
  - Abort at that edge; next cycle lk_en=0 and no resp_valid for the aborted transaction.
  - Pointer, lockout counter and latched code are cleared.

Optional Feature:
ADMIN_BYPASS_EN
- Defined:
  - In LOCKOUT, req_valid[1] is granted (req_ready[1]=1) and serviced through SEND/WAIT/RESP.
  - If that response has alert=0, lockout terminates and the block returns to IDLE; otherwise LOCKOUT restarts with a full count.
  - req_valid[0] is still refused.
- Undefined: LOCKOUT refuses both requesters until the count expires.

Test Plan:
1. Requester 0 valid at T, mode=1, code digits 0,1,0,3 (req_code[15:0]=16'h3010); locker model unlock=1 -> lk_en=1 in T+1..T+4 with lk_code 0,1,0,3; resp_valid=2'b01, resp_unlock=1, resp_err=0 at T+6 (RESULT_LAT=1).
2. Both requesters valid continuously from reset -> grants alternate 0,1,0,1; each resp_valid matches its grant; no overlap of lk_en bursts.
3. Locker returns alert=1 with LOCKOUT_CYCLES=8 -> locked_out=1 for exactly 8 cycles, req_ready=0 throughout, then the first pending request is granted in the next IDLE cycle.
4. RST pulsed for one cycle during the third SEND cycle -> lk_en=0 the following cycle, busy=0, no resp_valid; after reset, requester 0 wins over a simultaneous requester 1.
5. Requester 1 mode=0, digits 5,6,7,8 -> lk_mode=0 for all four strobes, lk_code 5,6,7,8; lk_mode returns to 1 in WAIT.
6. Lockout active, requester 1 valid -> ADMIN_BYPASS_EN defined: granted; with alert=0, locked_out drops after RESP. Undefined: req_ready[1] stays 0 until the lockout expires.
